fft_frame_ctrl: RTL and testbench
=================================

// Module: fft_frame_ctrl
// PURPOSE
// - Frame controller directly upstream of the FFT address generator. Accepts one real audio sample per
//   valid/ready beat and writes a 512-point frame into RAM0 in bit-reversed order.
// - Then pulses fft_start and holds bf_enable through all levels plus the butterfly pipeline drain.
// - Finally reports frame_done and the RAM bank that holds the result.
// PARAMETERS
// - BIT_WIDTH   16  real/imag sample width; RAM word is 2*BIT_WIDTH ({re, im})
// - LEVEL       9   log2(N), N = 512 points
// - BF_LATENCY  2   butterfly/write-back pipeline depth (cycles bf_enable is held after fft_done)
// - BITREV      1   1: load address = bit-reverse(sample index); 0: natural order
// PORTS
// - clk            in   1            system clock
// - reset          in   1            synchronous, active-low reset
// - sample_valid   in   1            upstream sample present
// - sample_in      in   BIT_WIDTH    signed real sample; imag part is forced to 0
// - sample_ready   out  1            sample accepted on clk edge when sample_valid & sample_ready
// - load_we        out  1            RAM0 write enable during load
// - load_addr      out  LEVEL        RAM0 write address
// - load_data      out  2*BIT_WIDTH  {sample_in, BIT_WIDTH'(0)}
// - fft_load       out  1            to address generator: load phase active (forces read_sel = 1)
// - fft_start      out  1            to address generator: one-cycle start pulse
// - bf_enable      out  1            to address generator/butterfly: compute phase active
// - fft_done       in   1            from address generator: all LEVEL levels issued (combinational)
// - busy           out  1            high from first accepted sample until frame_done
// - frame_done     out  1            one-cycle pulse when the result is complete in RAM
// - result_bank    out  1            RAM holding the result: constant LEVEL[0] (1 = RAM1 for LEVEL = 9)
// BEHAVIOUR
// - FSM states: IDLE, LOAD, START, RUN, DRAIN, DONE.
// - Reset (reset == 0 at clk edge) from any state:
//   - state = IDLE; sample counter = 0; drain counter = 0.
//   - Outputs: sample_ready = 1, fft_load = 1; all other outputs 0.
//   - An in-flight frame is abandoned; RAM contents are not cleared.
// - IDLE/LOAD:
//   - sample_ready = 1; fft_load = 1.
//   - load_we = sample_valid, same cycle (combinational). load_data = {sample_in, 0}.
//   - load_addr = BITREV ? bitrev(cnt) : cnt.
//   - Each accept: cnt increments. IDLE -> LOAD on the first accept; busy goes high the next cycle.
//   - Accept with cnt == N-1: cnt wraps to 0, next state = START.
// - START (1 cycle):
//   - fft_start = 1; sample_ready = 0; fft_load = 0; bf_enable = 0.
//   - fft_done is ignored here (it may still be high from the previous frame). Next state = RUN.
// - RUN:
//   - bf_enable = 1. The address generator resets its counters at the START->RUN edge.
//   - When fft_done == 1: next state = DRAIN with drain counter = 0. bf_enable stays 1.
// - DRAIN:
//   - bf_enable = 1 for exactly BF_LATENCY cycles so the delayed write enables flush.
//   - Then next state = DONE. BF_LATENCY = 0 skips DRAIN (RUN -> DONE).
// - DONE (1 cycle):
//   - frame_done = 1, bf_enable = 0. Next state = IDLE; busy falls with it.
// - Outside IDLE/LOAD: sample_ready = 0 and sample_valid is ignored; no back-pressure buffering.
// - Latency: last sample accept -> frame_done = 1 + LEVEL*(N/2) + BF_LATENCY + 1 cycles (2308 at defaults).
// - fft_start and frame_done are never high in the same cycle. fft_start is never high twice per frame.
// STRUCTURE
// - Package fft_pkg holds:
//   - localparams N_POINTS and N_BF (= N_POINTS/2).
//   - typedef enum logic [2:0] ctrl_state_t {IDLE, LOAD, START, RUN, DRAIN, DONE}.
//   - function bitrev(input [LEVEL-1:0]).
// - One natural sub-module: fft_bitrev_addr, a parameterised combinational reverser (LEVEL bits).
// - FSM, sample counter and drain counter stay in this module.
// TESTING
// - Reset held 3 cycles -> sample_ready = 1, fft_load = 1, busy = fft_start = bf_enable = frame_done = 0.
// - Stream 512 samples with no gaps; sample k = k:
//   - load_addr for k = 1 is 256, for k = 2 is 128, for k = 511 is 511.
//   - fft_start pulses 1 cycle after the 512th accept.
// - Stream with random sample_valid gaps (~50%) -> exactly 512 load_we pulses; START is entered only after the 512th.
// - After START, hold fft_done = 0 for 2304 cycles, then 1:
//   - bf_enable high for 2304 + 2 cycles.
//   - frame_done pulse on the following cycle; result_bank = 1.
// - Drive fft_done = 1 during START -> ignored; RUN still entered; bf_enable asserted.
// - Deassert reset mid-RUN (cycle 1000) -> next cycle IDLE, bf_enable = 0.
//   - A new 512-sample frame then completes normally with the load addresses restarting at 0.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// fft_pkg: shared definitions for the FFT frame controller slice.
// Holds the default transform geometry, the controller state encoding and a
// software-style bit-reversal helper for LEVEL-bit sample indices.
package fft_pkg;

    localparam int FFT_LEVEL     = 9;
    localparam int FFT_BIT_WIDTH = 16;
    localparam int N_POINTS      = 1 << FFT_LEVEL;
    localparam int N_BF          = N_POINTS / 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Mirror the index bits so bit 0 becomes the MSB of the result.
    function automatic logic [FFT_LEVEL-1:0] bitrev(input logic [FFT_LEVEL-1:0] idx);
        logic [FFT_LEVEL-1:0] rev;
        rev = '0;
        for (int i = 0; i < FFT_LEVEL; i++) begin
            rev[i] = idx[FFT_LEVEL-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: sample stream plus RAM0 load port of the frame controller.
// Ports (signals):
//   sample_valid / sample_in  : upstream sample beat (source -> controller)
//   sample_ready              : controller can take a sample this cycle
//   load_we / load_addr / load_data : RAM0 write port driven during loading
// Modports: master = sample source / RAM side, slave = the frame controller.
interface fft_frame_ctrl_if
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = FFT_BIT_WIDTH,
    parameter int LEVEL     = FFT_LEVEL
) ();

    logic                          sample_valid;
    logic signed [BIT_WIDTH-1:0]   sample_in;
    logic                          sample_ready;
    logic                          load_we;
    logic [LEVEL-1:0]              load_addr;
    logic [2*BIT_WIDTH-1:0]        load_data;

    modport master (
        output sample_valid,
        output sample_in,
        input  sample_ready,
        input  load_we,
        input  load_addr,
        input  load_data
    );

    modport slave (
        input  sample_valid,
        input  sample_in,
        output sample_ready,
        output load_we,
        output load_addr,
        output load_data
    );

endinterface

// File: rtl/fft_frame_ctrl_bitrev.sv
// fft_bitrev_addr: purely combinational WIDTH-bit address reverser.
// Ports:
//   addr_in  : natural-order index
//   addr_out : addr_in with its bit order mirrored
module fft_bitrev_addr #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] addr_in,
    output logic [WIDTH-1:0] addr_out
);

    always_comb begin
        addr_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            addr_out[i] = addr_in[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: loads one N-point real frame into RAM0 (optionally in
// bit-reversed order), kicks the FFT address generator, keeps the butterflies
// enabled until the write-back pipeline has drained, then flags completion.
// Ports:
//   clk, reset    : clock and synchronous active-low reset
//   smp (slave)   : sample valid/ready stream in, RAM0 write port out
//   fft_load      : load phase active (address generator selects RAM0)
//   fft_start     : one-cycle start pulse to the address generator
//   bf_enable     : compute phase active, held through the pipeline drain
//   fft_done      : all levels issued (from the address generator)
//   busy          : a frame is in flight
//   frame_done    : one-cycle completion pulse
//   result_bank   : RAM bank holding the finished spectrum
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH  = FFT_BIT_WIDTH,
    parameter int LEVEL      = FFT_LEVEL,
    parameter int BF_LATENCY = 2,
    parameter int BITREV     = 1
) (
    input  logic               clk,
    input  logic               reset,
    fft_frame_ctrl_if.slave    smp,
    output logic               fft_load,
    output logic               fft_start,
    output logic               bf_enable,
    input  logic               fft_done,
    output logic               busy,
    output logic               frame_done,
    output logic               result_bank
);

    localparam logic [LEVEL-1:0] LAST_IDX = {LEVEL{1'b1}};
    localparam int DRAIN_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((BF_LATENCY > 0) ? BF_LATENCY - 1 : 0);
    // Levels ping-pong between the two RAMs, so an odd level count ends in RAM1.
    localparam logic RESULT_BANK = ((LEVEL % 2) != 0);

    ctrl_state_t         state_q, state_d;
    logic [LEVEL-1:0]    cnt_q, cnt_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                sample_ready_q, sample_ready_d;
    logic                fft_load_q, fft_load_d;
    logic                fft_start_q, fft_start_d;
    logic                bf_enable_q, bf_enable_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                result_bank_q, result_bank_d;

    logic                accept;
    logic [LEVEL-1:0]    rev_addr;

    fft_bitrev_addr #(
        .WIDTH (LEVEL)
    ) u_bitrev (
        .addr_in  (cnt_q),
        .addr_out (rev_addr)
    );

    // sample_ready_q is high exactly in IDLE/LOAD, so it doubles as the load-phase qualifier.
    assign accept = sample_ready_q & smp.sample_valid;

    // The RAM0 write port follows the accept combinationally so each sample
    // lands in the same cycle it is handed over.
    assign smp.sample_ready = sample_ready_q;
    assign smp.load_we      = accept;
    assign smp.load_addr    = (BITREV != 0) ? rev_addr : cnt_q;
    assign smp.load_data    = {smp.sample_in, {BIT_WIDTH{1'b0}}};

    assign fft_load    = fft_load_q;
    assign fft_start   = fft_start_q;
    assign bf_enable   = bf_enable_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign result_bank = result_bank_q;

    // Next-state logic; outputs are decoded from the next state so they are
    // registered yet line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        drain_d       = drain_q;
        result_bank_d = result_bank_q;

        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    // Counter wraps to 0 naturally after the last index.
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_IDX) ? START : LOAD;
                end
            end
            START: begin
                // fft_done may still be high from the previous frame; ignore it.
                state_d = RUN;
            end
            RUN: begin
                if (fft_done) begin
                    drain_d = '0;
                    state_d = (BF_LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            result_bank_d = RESULT_BANK;
        end

        sample_ready_d = (state_d == IDLE) || (state_d == LOAD);
        fft_load_d     = (state_d == IDLE) || (state_d == LOAD);
        fft_start_d    = (state_d == START);
        bf_enable_d    = (state_d == RUN) || (state_d == DRAIN);
        busy_d         = (state_d != IDLE);
        frame_done_d   = (state_d == DONE);
    end

    // Single state register; reset abandons any in-flight frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            drain_q        <= '0;
            sample_ready_q <= 1'b1;
            fft_load_q     <= 1'b1;
            fft_start_q    <= 1'b0;
            bf_enable_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            result_bank_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            drain_q        <= drain_d;
            sample_ready_q <= sample_ready_d;
            fft_load_q     <= fft_load_d;
            fft_start_q    <= fft_start_d;
            bf_enable_q    <= bf_enable_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            result_bank_q  <= result_bank_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: self-checking bench for fft_frame_ctrl.
// Every accepted sample pushes its expected RAM0 write onto a scoreboard queue;
// a negedge monitor pops and compares each load_we beat. A small table of
// sample-index -> address/data records is checked against the logged writes,
// and the compute phase is timed against the expected bf_enable window.
module tb_fft_frame_ctrl;

    logic clk;
    logic reset;
    logic fft_load, fft_start, bf_enable, fft_done;
    logic busy, frame_done, result_bank;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          k;
        logic [8:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[9];
    logic [8:0]  addr_log[512];
    logic [31:0] data_log[512];
    int          frame_writes = 0;
    int          exp_k = 0;

    fft_frame_ctrl_if smp_if ();

    fft_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .smp         (smp_if),
        .fft_load    (fft_load),
        .fft_start   (fft_start),
        .bf_enable   (bf_enable),
        .fft_done    (fft_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .result_bank (result_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] tbRev(input int k);
        logic [8:0] kk;
        logic [8:0] r;
        kk = k[8:0];
        for (int i = 0; i < 9; i++) r[i] = kk[8-i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle of stream input just after the clock edge.
    task automatic applyStimulus(input logic v, input logic [15:0] s);
        @(posedge clk);
        #1;
        smp_if.sample_valid = v;
        smp_if.sample_in    = s;
        if (v) begin
            exp_q.push_back({tbRev(exp_k), s, 16'h0000});
            exp_k++;
        end
    endtask

    // Scoreboard monitor for RAM0 writes and start-pulse sanity.
    always @(negedge clk) begin
        if (smp_if.load_we) begin
            checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("load_addr", 32'(smp_if.load_addr), 32'(e.addr));
                checkOutput("load_data", smp_if.load_data, e.data);
            end
            if (frame_writes < 512) begin
                addr_log[frame_writes] = smp_if.load_addr;
                data_log[frame_writes] = smp_if.load_data;
            end
            frame_writes++;
        end
        if (fft_start) begin
            checkOutput("start_after_512", frame_writes, 512);
            checkOutput("start_vs_frame_done", 32'(frame_done), 32'd0);
        end
    end

    task automatic streamFrame(input bit gaps, input bit check_busy, input bit done_in_start);
        int  k = 0;
        int  guard = 0;
        bit  v;
        frame_writes = 0;
        exp_k = 0;
        while (k < 512 && guard < 4000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(v, k[15:0]);
            if (v) k++;
            guard++;
            if (check_busy && v && k == 1) begin
                @(negedge clk);
                checkOutput("busy_before_first_accept", 32'(busy), 32'd0);
            end
            if (check_busy && v && k == 2) begin
                @(negedge clk);
                checkOutput("busy_after_first_accept", 32'(busy), 32'd1);
            end
        end
        applyStimulus(1'b0, 16'h0000);
        if (done_in_start) fft_done = 1'b1;
        @(negedge clk);
        checkOutput("start_fft_start", 32'(fft_start), 32'd1);
        checkOutput("start_sample_ready", 32'(smp_if.sample_ready), 32'd0);
        checkOutput("start_fft_load", 32'(fft_load), 32'd0);
        checkOutput("start_bf_enable", 32'(bf_enable), 32'd0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("frame_write_count", frame_writes, 512);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic runCompute(input int done_cycle, input int reset_at);
        int bf_cnt = 0;
        bit fin = 1'b0;
        bit normal = 1'b0;
        for (int c = 1; c <= 6000 && !fin; c++) begin
            @(posedge clk);
            #1;
            fft_done = (c >= done_cycle);
            reset    = (c == reset_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (reset_at != 0 && c == reset_at) begin
                checkOutput("bf_enable_before_reset", 32'(bf_enable), 32'd1);
            end
            if (reset_at != 0 && c == reset_at + 1) begin
                checkOutput("rst_bf_enable", 32'(bf_enable), 32'd0);
                checkOutput("rst_sample_ready", 32'(smp_if.sample_ready), 32'd1);
                checkOutput("rst_fft_load", 32'(fft_load), 32'd1);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_fft_start", 32'(fft_start), 32'd0);
                fin = 1'b1;
            end else if (bf_enable) begin
                bf_cnt++;
            end else if (bf_cnt > 0) begin
                checkOutput("bf_enable_cycles", bf_cnt, 2306);
                checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
                checkOutput("result_bank", 32'(result_bank), 32'd1);
                checkOutput("done_busy", 32'(busy), 32'd1);
                fin = 1'b1;
                normal = 1'b1;
            end
        end
        fft_done = 1'b0;
        reset    = 1'b1;
        checkOutput("compute_finished", 32'(fin), 32'd1);
        if (normal) begin
            @(negedge clk);
            checkOutput("frame_done_one_cycle", 32'(frame_done), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_sample_ready", 32'(smp_if.sample_ready), 32'd1);
        end
    endtask

    task automatic checkTable();
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("addr_k%0d", vecs[i].k), 32'(addr_log[vecs[i].k]), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("data_k%0d", vecs[i].k), data_log[vecs[i].k], vecs[i].exp_data);
        end
    endtask

    initial begin
        vecs[0] = '{0,   9'd0,   32'h0000_0000};
        vecs[1] = '{1,   9'd256, 32'h0001_0000};
        vecs[2] = '{2,   9'd128, 32'h0002_0000};
        vecs[3] = '{3,   9'd384, 32'h0003_0000};
        vecs[4] = '{4,   9'd64,  32'h0004_0000};
        vecs[5] = '{255, 9'd510, 32'h00FF_0000};
        vecs[6] = '{256, 9'd1,   32'h0100_0000};
        vecs[7] = '{510, 9'd255, 32'h01FE_0000};
        vecs[8] = '{511, 9'd511, 32'h01FF_0000};

        reset               = 1'b0;
        fft_done            = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_sample_ready", 32'(smp_if.sample_ready), 32'd1);
        checkOutput("reset_fft_load", 32'(fft_load), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fft_start", 32'(fft_start), 32'd0);
        checkOutput("reset_bf_enable", 32'(bf_enable), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_load_we", 32'(smp_if.load_we), 32'd0);

        $display("[TB] frame 1: gapless stream");
        streamFrame(1'b0, 1'b1, 1'b0);
        checkTable();
        runCompute(2304, 0);

        $display("[TB] frame 2: random valid gaps");
        streamFrame(1'b1, 1'b0, 1'b0);
        runCompute(2304, 0);

        $display("[TB] frame 3: fft_done high during START");
        streamFrame(1'b0, 1'b0, 1'b1);
        runCompute(2304, 0);

        $display("[TB] frame 4: reset in the middle of RUN");
        streamFrame(1'b0, 1'b0, 1'b0);
        runCompute(99999, 1000);

        $display("[TB] frame 5: new frame after reset");
        streamFrame(1'b0, 1'b0, 1'b0);
        checkTable();
        runCompute(2304, 0);

        checkOutput("final_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
